// File: rtl/ds1302_slave.sv
// ds1302_slave: DS1302 3-wire RTC responder with BCD timekeeping
// Ports: clk, rst_n (sync active-low); ds1302_ce/ds1302_sclk in, ds1302_io inout
// (driven only in read-data phase); time_* live clock registers; wp control bit 7.
module ds1302_slave #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ds1302_ce,
  input  logic       ds1302_sclk,
  inout  wire        ds1302_io,
  output logic [7:0] time_second,
  output logic [7:0] time_minute,
  output logic [7:0] time_hour,
  output logic [7:0] time_date,
  output logic [7:0] time_month,
  output logic [7:0] time_week,
  output logic [7:0] time_year,
  output logic       wp
);
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, IGNORE} state_t;
  state_t state, state_n;
  logic [1:0] ce_s, sclk_s, io_s;
  logic ce_d, sclk_d, ce, rise, fall, ce_rise, last, wr, wr_ok, tick, leap;
  logic c_s, c_m, c_h, c_d, c_mo, oe, io_out, burst, ram;
  logic [6:0] sh;
  logic [7:0] wdata, we, rd_byte, dmax;
  logic [7:0] rbuf [8];
  logic [4:0] addr;
  logic [3:0] idx;
  logic [2:0] cnt, tgt;
  logic [1:0] ysum;
  logic [31:0] pre;
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, lim, base);
    return v == lim ? base : v[3:0] == 4'd9 ? {v[7:4] + 4'd1, 4'd0} : v + 8'd1;
  endfunction
  assign ds1302_io = oe ? io_out : 1'bz;
  assign ce = ce_s[1];
  assign ce_rise = ce_s[1] & ~ce_d;
  assign rise = sclk_s[1] & ~sclk_d;
  assign fall = ~sclk_s[1] & sclk_d;
  // Byte as it stands once the current IO bit is shifted in (LSB first).
  assign wdata = {io_s[1], sh};
  assign last = rise && cnt == 3'd7;
  assign wr = state == WDATA && last;
  assign tgt = burst ? idx[2:0] : addr[2:0];
  assign wr_ok = wr && !ram && (burst || addr[4:3] == 2'b00) && (tgt == 3'd7 || !wp);
  assign we = wr_ok ? 8'd1 << tgt : 8'd0;
  assign rd_byte = ram ? 8'h00 : burst ? (idx[3] ? 8'h00 : rbuf[idx[2:0]])
                 : (addr[4:3] != 2'b00 ? 8'h00 : rbuf[addr[2:0]]);
  assign tick = !time_second[7] && pre == 32'(CLK_FREQ - 1);
  // 10 = 2 mod 4, so an odd tens digit adds 2 to the units digit's residue.
  assign ysum = time_year[1:0] + {time_year[4], 1'b0};
  assign leap = ysum == 2'd0;
  assign dmax = time_month == 8'h02 ? (leap ? 8'h29 : 8'h28)
              : (time_month == 8'h04 || time_month == 8'h06 || time_month == 8'h09 ||
                 time_month == 8'h11) ? 8'h30 : 8'h31;
  assign c_s = tick && time_second == 8'h59;
  assign c_m = c_s && time_minute == 8'h59;
  assign c_h = c_m && time_hour[6:0] == 7'h23;
  assign c_d = c_h && time_date == dmax;
  assign c_mo = c_d && time_month == 8'h12;
  always_comb begin
    state_n = state;
    if (!ce) state_n = IDLE;
    else if (state == IDLE && ce_rise) state_n = CMD;
    else if (state == CMD && last) state_n = !wdata[7] ? IGNORE : wdata[0] ? RDATA : WDATA;
    else if (wr && !(burst && idx < 4'd7)) state_n = IGNORE;
  end
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {ce_s, sclk_s, io_s, ce_d, sclk_d} <= '0;
      time_second <= 8'h80;
      time_minute <= 8'h00;
      time_hour <= 8'h00;
      time_date <= 8'h01;
      time_month <= 8'h01;
      time_week <= 8'h01;
      time_year <= 8'h00;
      wp <= 1'b0;
      pre <= '0;
      {oe, io_out, burst, ram} <= '0;
      sh <= '0;
      addr <= '0;
      idx <= '0;
      cnt <= '0;
    end else begin
      ce_s <= {ce_s[0], ds1302_ce};
      sclk_s <= {sclk_s[0], ds1302_sclk};
      io_s <= {io_s[0], ds1302_io};
      ce_d <= ce_s[1];
      sclk_d <= sclk_s[1];
      pre <= (time_second[7] || tick || we[0]) ? '0 : pre + 32'd1;
      if (tick) time_second <= bcd_inc(time_second, 8'h59, 8'h00);
      if (c_s) time_minute <= bcd_inc(time_minute, 8'h59, 8'h00);
      if (c_m) time_hour <= {time_hour[7], 7'(bcd_inc({1'b0, time_hour[6:0]}, 8'h23, 8'h00))};
      if (c_h) time_week <= bcd_inc(time_week, 8'h07, 8'h01);
      if (c_h) time_date <= bcd_inc(time_date, dmax, 8'h01);
      if (c_d) time_month <= bcd_inc(time_month, 8'h12, 8'h01);
      if (c_mo) time_year <= bcd_inc(time_year, 8'h99, 8'h00);
      // Commits come after the tick updates so a same-cycle write wins.
      if (we[0]) time_second <= wdata;
      if (we[1]) time_minute <= wdata;
      if (we[2]) time_hour <= wdata;
      if (we[3]) time_date <= wdata;
      if (we[4]) time_month <= wdata;
      if (we[5]) time_week <= wdata;
      if (we[6]) time_year <= wdata;
      if (we[7]) wp <= wdata[7];
      if (!ce) begin
        oe <= 1'b0;
        cnt <= '0;
      end else if ((state == CMD || state == WDATA) && rise) begin
        sh <= wdata[7:1];
        cnt <= cnt + 3'd1;
      end else if (state == RDATA && fall) begin
        oe <= 1'b1;
        io_out <= rd_byte[cnt];
        cnt <= cnt + 3'd1;
        if (cnt == 3'd7 && burst && !idx[3]) idx <= idx + 4'd1;
      end
      if (state == CMD && last) begin
        addr <= wdata[5:1];
        ram <= wdata[6];
        burst <= wdata[5:1] == 5'h1f && !wdata[6];
        idx <= '0;
        rbuf[0] <= time_second;
        rbuf[1] <= time_minute;
        rbuf[2] <= time_hour;
        rbuf[3] <= time_date;
        rbuf[4] <= time_month;
        rbuf[5] <= time_week;
        rbuf[6] <= time_year;
        rbuf[7] <= {wp, 7'd0};
      end
      if (wr && burst) idx <= idx + 4'd1;
    end
  end
endmodule

// File: tb/tb_ds1302_slave.sv
// tb_ds1302_slave: directed bench for ds1302_slave using CLK_FREQ=16
module tb_ds1302_slave;
  logic clk = 0, rst_n = 0, ce = 0, sclk = 0, tb_oe = 0, tb_io = 0;
  wire io;
  logic [7:0] sec, min, hour, date, mon, week, year, d;
  logic wp;
  int passed = 0, total = 0;
  pullup (io);
  assign io = tb_oe ? tb_io : 1'bz;
  ds1302_slave #(.CLK_FREQ(16)) dut (
    .clk(clk), .rst_n(rst_n), .ds1302_ce(ce), .ds1302_sclk(sclk), .ds1302_io(io),
    .time_second(sec), .time_minute(min), .time_hour(hour), .time_date(date),
    .time_month(mon), .time_week(week), .time_year(year), .wp(wp)
  );
  always #5 clk = ~clk;
  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic send_byte(input logic [7:0] b);
    tb_oe = 1;
    for (int i = 0; i < 8; i++) begin
      tb_io = b[i];
      sclk = 0;
      clks(5);
      sclk = 1;
      clks(5);
    end
  endtask
  task automatic get_byte(output logic [7:0] b);
    tb_oe = 0;
    for (int i = 0; i < 8; i++) begin
      sclk = 0;
      clks(5);
      b[i] = io;
      sclk = 1;
      clks(5);
    end
  endtask
  task automatic begin_xfer(input logic [7:0] cmd);
    ce = 1;
    clks(5);
    send_byte(cmd);
  endtask
  task automatic end_xfer();
    ce = 0;
    sclk = 0;
    tb_oe = 0;
    clks(6);
  endtask
  task automatic wr(input logic [7:0] cmd, input logic [7:0] data);
    begin_xfer(cmd);
    send_byte(data);
    end_xfer();
  endtask
  task automatic rd(input logic [7:0] cmd, output logic [7:0] data);
    begin_xfer(cmd);
    get_byte(data);
    end_xfer();
  endtask
  task automatic burst_wr(input logic [7:0] y);
    logic [7:0] b [8];
    b = '{8'h00, 8'h59, 8'h23, 8'h28, 8'h02, 8'h07, y, 8'h00};
    begin_xfer(8'hbe);
    for (int i = 0; i < 8; i++) send_byte(b[i]);
    end_xfer();
  endtask
  initial begin
    logic [7:0] exp_b [9];
    clks(3);
    rst_n = 1;
    clks(2);
    chk("rst_sec", sec, 8'h80);
    chk("rst_min", min, 8'h00);
    chk("rst_date", date, 8'h01);
    chk("rst_week", week, 8'h01);
    chk("rst_wp", {7'd0, wp}, 8'h00);
    chk("rst_io_z", {7'd0, io}, 8'h01);
    rd(8'h81, d);
    chk("rd_sec", d, 8'h80);
    wr(8'h80, 8'h00);
    clks(960);
    chk("run_sec", sec, 8'h00);
    chk("run_min", min, 8'h01);
    wr(8'h80, 8'h80);
    chk("halt_sec", sec, 8'h80);
    chk("halt_min", min, 8'h01);
    burst_wr(8'h23);
    clks(960);
    chk("b23_date", date, 8'h01);
    chk("b23_mon", mon, 8'h03);
    chk("b23_week", week, 8'h01);
    chk("b23_hour", hour, 8'h00);
    chk("b23_min", min, 8'h00);
    chk("b23_year", year, 8'h23);
    burst_wr(8'h24);
    clks(960);
    chk("b24_date", date, 8'h29);
    chk("b24_mon", mon, 8'h02);
    chk("b24_week", week, 8'h01);
    chk("b24_hour", hour, 8'h00);
    chk("b24_min", min, 8'h00);
    wr(8'h80, 8'h80);
    chk("halt2_sec", sec, 8'h80);
    wr(8'h8e, 8'h80);
    chk("wp_set", {7'd0, wp}, 8'h01);
    wr(8'h82, 8'h45);
    chk("wp_blocks", min, 8'h00);
    wr(8'h8e, 8'hff);
    rd(8'h8f, d);
    chk("ctrl_rd", d, 8'h80);
    wr(8'h8e, 8'h00);
    chk("wp_clr", {7'd0, wp}, 8'h00);
    wr(8'h82, 8'h45);
    chk("wp_allows", min, 8'h45);
    wr(8'h84, 8'h13);
    chk("hour_wr", hour, 8'h13);
    ce = 1;
    clks(5);
    tb_oe = 1;
    for (int i = 0; i < 4; i++) begin
      tb_io = i[0];
      sclk = 0;
      clks(5);
      sclk = 1;
      clks(5);
    end
    end_xfer();
    chk("abort_io_z", {7'd0, io}, 8'h01);
    chk("abort_hour", hour, 8'h13);
    rd(8'h85, d);
    chk("rd_hour", d, 8'h13);
    rd(8'h83, d);
    chk("rd_min", d, 8'h45);
    rd(8'hc1, d);
    chk("rd_ram", d, 8'h00);
    rd(8'h91, d);
    chk("rd_addr8", d, 8'h00);
    begin_xfer(8'h83);
    get_byte(d);
    chk("rep0", d, 8'h45);
    get_byte(d);
    chk("rep1", d, 8'h45);
    end_xfer();
    exp_b = '{8'h80, 8'h45, 8'h13, 8'h29, 8'h02, 8'h01, 8'h24, 8'h00, 8'h00};
    begin_xfer(8'hbf);
    for (int i = 0; i < 9; i++) begin
      get_byte(d);
      chk($sformatf("burst_rd%0d", i), d, exp_b[i]);
    end
    end_xfer();
    begin_xfer(8'h02);
    get_byte(d);
    chk("ignore_io_z", d, 8'hff);
    end_xfer();
    begin_xfer(8'hbf);
    tb_oe = 0;
    sclk = 0;
    clks(5);
    chk("mid_io_drv", {7'd0, io}, 8'h00);
    rst_n = 0;
    clks(1);
    chk("mid_rst_io", {7'd0, io}, 8'h01);
    chk("mid_rst_min", min, 8'h00);
    chk("mid_rst_hour", hour, 8'h00);
    rst_n = 1;
    end_xfer();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ds1302_slave.md
# ds1302_slave

Synthesizable responder for the DS1302 3-wire RTC protocol. It decodes CE/SCLK/IO transactions driven by a DS1302 master, holds BCD timekeeping registers and advances them from a clock-derived 1 Hz tick. It stands in for the physical chip in loopback and emulation builds, attached to the same three pins the master drives.

## Interface
Parameters:
- CLK_FREQ, 50_000_000: `clk` frequency in Hz; the 1 Hz prescaler terminal count is CLK_FREQ-1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, synchronous, active-low
- ds1302_ce  input  1  chip enable from master
- ds1302_sclk  input  1  serial clock from master
- ds1302_io  inout  1  serial data; driven only in the read-data phase, otherwise high-Z
- time_second, time_minute, time_hour, time_date, time_month, time_week, time_year  output  8 each  live register contents, for observation
- wp  output  1  control register bit 7 (write protect)

## Operation
- CE, SCLK and IO-in pass through 2-FF synchronizers. Edge detection uses the synchronized signals.
- Reset values:
  - second 0x80 (CH=1, halted), minute 0x00, hour 0x00, date 0x01, month 0x01, week 0x01, year 0x00, control 0x00, prescaler 0.
  - FSM in IDLE, IO high-Z.
- FSM states: IDLE, CMD, WDATA, RDATA, IGNORE.
  - IDLE: CE rising moves to CMD with bit count 0.
  - CMD: shift IO on each SCLK rise, LSB first. After 8 bits, decode the command byte: bit0 = read (1) / write (0), bits5:1 = address, bit6 = RAM (1) / clock (0), bit7 must be 1.
    - bit7=0 goes to IGNORE.
    - A write command goes to WDATA.
    - A read command goes to RDATA and snapshots all 8 clock/control registers into a read buffer.
  - WDATA: shift 8 bits on SCLK rises, LSB first. On the 8th bit, commit the byte to the addressed register.
  - RDATA: on each SCLK fall, drive the next buffered bit, LSB first. The first bit goes out on the fall after command bit 8.
  - IGNORE: no IO drive and no writes until CE falls.
  - CE low in any state returns the FSM to IDLE and releases IO.
- Address map (clock, bit6=0): 0 sec, 1 min, 2 hour, 3 date, 4 month, 5 week, 6 year, 7 control.
  - Addresses 8–30 read 0x00 and ignore writes.
  - Address 31 is clock burst (0xBE write / 0xBF read): bytes stream in address order 0..7, each byte handled as its own write or read. After byte 7, burst writes go to IGNORE and burst reads drive 0x00.
  - Single-byte mode: after one data byte, writes go to IGNORE; reads repeat the same byte until CE falls.
- RAM commands (bit6=1): reads return 0x00, writes are discarded.
- When wp=1, writes to addresses 0–6 are discarded; the control register is always writable. Only bit 7 of control is stored; other bits read 0.
- Timekeeping:
  - When CH=0, the prescaler counts to CLK_FREQ-1 and issues a 1-cycle tick, then wraps to 0. When CH=1, the prescaler holds at 0.
  - On tick, increment BCD with carry chain: second 59 to 00, minute 59 to 00, hour 23 to 00 (24-hour only; hour bit 7 stored and ignored).
  - On hour wrap, week 7 to 1, and date increments past month length to 01. Month lengths are 31/30; February is 29 when year mod 4 == 0, else 28.
  - Month 12 wraps to 01 and increments year; year 99 wraps to 00.
- Any commit to second resets the prescaler to 0.
- If a tick and a commit hit the same register in one cycle, the commit wins. Carries into other registers still apply.
- Out-of-range BCD written by the master is stored as-is. Increment applies raw BCD nibble rules (low nibble 9 rolls over) and compares against the limit for equality only.

## Timing
- Master SCLK high and low times must each be ≥4 `clk` periods; CE setup to first SCLK rise must be ≥4 `clk` periods.
- Edge-to-action latency is 3 `clk` cycles (2 synchronizer stages + edge register). This applies to:
  - IO sample on SCLK rise,
  - IO output change on SCLK fall,
  - register commit (visible on `time_*` on the cycle after).
- IO is released within 3 cycles of CE falling.
- The read snapshot is taken in the decode cycle. A tick during a read does not alter bytes already buffered.
- A reset asserted mid-transaction takes effect on the next `clk` edge: all registers return to reset values and IO goes high-Z.

## Test plan
- Reset, then single read of 0x81 -> IO returns 0x80 LSB first; `time_second`=0x80.
- Write 0x80←0x00 with CLK_FREQ=16, wait 16×60 cycles -> `time_minute`=0x01, `time_second`=0x00.
- Burst write 0xBE with 00,59,23,28,02,07,23,00 (2023-02-28, 23:59:00) then 60 ticks -> date=0x01, month=0x03, week=0x01, hour=0x00, minute=0x00. Repeat with year 0x24 -> date=0x29, month=0x02.
- Write control 0x8E←0x80, then 0x82←0x45 -> minute unchanged. Then write 0x8E←0x00 and repeat -> minute=0x45.
- Drop CE after 4 command bits, then issue a valid read 0x85 -> no write occurred, IO high-Z before the read, read returns the current hour.
- Read 0x83 and 0xC1 (RAM) -> second byte reads 0x00. Command 0x02 (bit7=0) -> IO never driven during the remaining 8 SCLKs.
